// File: rtl/vend_checkout.sv
// Vending checkout controller: takes a priced selection, collects coins,
// then either dispenses with change or refunds the collected credit.
module vend_checkout #(
  parameter int TIMEOUT = 1000,
  parameter int N       = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] commodity,
  input  logic [4:0]   total,
  input  logic         coin_valid,
  input  logic [1:0]   coin_value,
  input  logic         cancel,
  output logic         ready,
  output logic [5:0]   credit,
  output logic         dispense,
  output logic [N-1:0] items,
  output logic         change_valid,
  output logic [5:0]   change,
  output logic         err
);

  // The timer only ever holds 0..TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DISPENSE,
    S_REFUND
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      price_q, price_d;
  logic [N-1:0]    sel_q, sel_d;
  logic [5:0]      credit_q, credit_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            ready_q, ready_d;
  logic            dispense_q, dispense_d;
  logic [N-1:0]    items_q, items_d;
  logic            change_valid_q, change_valid_d;
  logic [5:0]      change_q, change_d;
  logic            err_q, err_d;
  logic [5:0]      pay_sum;

  // Coin code to value in units.
  function automatic logic [5:0] coin_units(input logic [1:0] code);
    logic [5:0] v;
    case (code)
      2'b00:   v = 6'd1;
      2'b01:   v = 6'd2;
      2'b10:   v = 6'd5;
      default: v = 6'd10;
    endcase
    return v;
  endfunction

  // Next-state and next-output computation for the checkout sequence.
  always_comb begin
    state_d        = state_q;
    price_d        = price_q;
    sel_d          = sel_q;
    credit_d       = credit_q;
    timer_d        = timer_q;
    err_d          = 1'b0;
    change_d       = 6'd0;
    // Credit never exceeds 40, so the 6-bit sum cannot wrap.
    pay_sum        = credit_q + (coin_valid ? coin_units(coin_value) : 6'd0);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((total != 5'd0) && (commodity != '0)) begin
            price_d  = total;
            sel_d    = commodity;
            credit_d = 6'd0;
            timer_d  = '0;
            state_d  = S_COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (cancel) begin
          // A coin arriving with cancel is still credited and refunded.
          credit_d = pay_sum;
          change_d = pay_sum;
          state_d  = S_REFUND;
        end else if (coin_valid) begin
          credit_d = pay_sum;
          timer_d  = '0;
          if (pay_sum >= {1'b0, price_q}) begin
            change_d = pay_sum - {1'b0, price_q};
            state_d  = S_DISPENSE;
          end
        end else if (timer_q == TIMER_LAST) begin
          change_d = credit_q;
          state_d  = S_REFUND;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DISPENSE, S_REFUND: begin
        credit_d = 6'd0;
        timer_d  = '0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered so they line up with the state they describe.
    ready_d        = (state_d == S_IDLE);
    dispense_d     = (state_d == S_DISPENSE);
    items_d        = (state_d == S_DISPENSE) ? sel_q : '0;
    change_valid_d = (state_d == S_DISPENSE) || (state_d == S_REFUND);
    if (!change_valid_d) begin
      change_d = 6'd0;
    end
  end

  // State and output registers with synchronous reset to an empty IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      price_q        <= 5'd0;
      sel_q          <= '0;
      credit_q       <= 6'd0;
      timer_q        <= '0;
      ready_q        <= 1'b1;
      dispense_q     <= 1'b0;
      items_q        <= '0;
      change_valid_q <= 1'b0;
      change_q       <= 6'd0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      price_q        <= price_d;
      sel_q          <= sel_d;
      credit_q       <= credit_d;
      timer_q        <= timer_d;
      ready_q        <= ready_d;
      dispense_q     <= dispense_d;
      items_q        <= items_d;
      change_valid_q <= change_valid_d;
      change_q       <= change_d;
      err_q          <= err_d;
    end
  end

  assign ready        = ready_q;
  assign credit       = credit_q;
  assign dispense     = dispense_q;
  assign items        = items_q;
  assign change_valid = change_valid_q;
  assign change       = change_q;
  assign err          = err_q;

endmodule

// File: tb/tb_vend_checkout.sv
// Scoreboard bench for vend_checkout: a purchase-level reference model
// predicts status and output events; a monitor compares them each cycle.
module tb_vend_checkout;
  localparam int N       = 6;
  localparam int TIMEOUT = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] commodity;
  logic [4:0]   total;
  logic         coin_valid;
  logic [1:0]   coin_value;
  logic         cancel;
  logic         ready;
  logic [5:0]   credit;
  logic         dispense;
  logic [N-1:0] items;
  logic         change_valid;
  logic [5:0]   change;
  logic         err;

  vend_checkout #(.TIMEOUT(TIMEOUT), .N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .commodity(commodity),
    .total(total), .coin_valid(coin_valid), .coin_value(coin_value),
    .cancel(cancel), .ready(ready), .credit(credit), .dispense(dispense),
    .items(items), .change_valid(change_valid), .change(change), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   kind;   // {dispense, change_valid, err}
    logic [N-1:0] items;
    logic [5:0]   change;
    int           due;
  } ev_t;

  typedef struct {
    logic       ready;
    logic [5:0] credit;
  } st_t;

  ev_t evq[$];
  st_t stq[$];

  int tests  = 0;
  int failed = 0;
  int edge_n = 0;

  logic [2:0]   last_kind;
  logic [N-1:0] last_items;
  logic [5:0]   last_change;
  int           disp_cnt = 0;

  // Purchase-level model: 0 = waiting for a customer, 1 = taking coins,
  // 2 = purchase settled (dispense/refund visible this cycle).
  int        m_mode   = 0;
  int        m_price  = 0;
  int        m_credit = 0;
  int        m_idle   = 0;
  logic [N-1:0] m_sel = '0;
  int        coin_tab [4] = '{1, 2, 5, 10};

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Apply the model to the inputs set for this cycle, record expectations,
  // then let the clock edge happen.
  task automatic step();
    ev_t e;
    st_t s;
    bit  have_ev;
    int  add;
    have_ev  = 0;
    e.kind   = 3'b000;
    e.items  = '0;
    e.change = 6'd0;
    e.due    = edge_n + 1;
    add      = coin_valid ? coin_tab[coin_value] : 0;
    if (reset) begin
      m_mode = 0; m_price = 0; m_credit = 0; m_idle = 0; m_sel = '0;
    end else if (m_mode == 0) begin
      if (start) begin
        if (total == 0 || commodity == 0) begin
          have_ev = 1; e.kind = 3'b001;
        end else begin
          m_mode = 1; m_price = total; m_sel = commodity; m_credit = 0; m_idle = 0;
        end
      end
    end else if (m_mode == 1) begin
      m_credit += add;
      if (cancel) begin
        have_ev = 1; e.kind = 3'b010; e.change = 6'(m_credit); m_mode = 2;
      end else if (coin_valid) begin
        m_idle = 0;
        if (m_credit >= m_price) begin
          have_ev = 1; e.kind = 3'b110; e.items = m_sel;
          e.change = 6'(m_credit - m_price); m_mode = 2;
        end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          have_ev = 1; e.kind = 3'b010; e.change = 6'(m_credit); m_mode = 2;
        end
      end
    end else begin
      m_mode = 0; m_credit = 0;
    end
    if (have_ev) evq.push_back(e);
    s.ready  = (m_mode == 0);
    s.credit = 6'(m_credit);
    stq.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0; start = 0; commodity = '0; total = 5'd0;
    coin_valid = 0; coin_value = 2'b00; cancel = 0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_start(input logic [N-1:0] c, input logic [4:0] t);
    clear_inputs(); start = 1; commodity = c; total = t; step(); clear_inputs();
  endtask

  task automatic do_coin(input logic [1:0] code, input logic cx);
    clear_inputs(); coin_valid = 1; coin_value = code; cancel = cx; step(); clear_inputs();
  endtask

  // Monitor: status every cycle, events whenever the DUT pulses.
  always @(negedge clk) begin
    st_t s;
    ev_t e;
    if (stq.size() > 0) begin
      s = stq.pop_front();
      chk("ready", ready, s.ready);
      chk("credit", credit, s.credit);
      if (dispense || change_valid || err) begin
        if (evq.size() == 0) begin
          chk("spurious_pulse", {dispense, change_valid, err}, 0);
        end else begin
          e = evq.pop_front();
          chk("event_kind", {dispense, change_valid, err}, e.kind);
          chk("event_cycle", edge_n, e.due);
          chk("event_items", items, e.items);
          chk("event_change", change, e.change);
          last_kind   = {dispense, change_valid, err};
          last_items  = items;
          last_change = change;
          if (dispense) disp_cnt++;
        end
      end else begin
        chk("quiet_items", items, 0);
        chk("quiet_change", change, 0);
        if (evq.size() > 0 && evq[0].due <= edge_n) begin
          chk("missed_event", 0, evq[0].kind);
          void'(evq.pop_front());
        end
      end
    end
  end

  initial begin
    int d0;
    int coin_pct;
    clear_inputs();
    reset = 1;
    step(); step();
    idle(2);

    // Exact change on two coins.
    do_start(6'b000011, 5'd10);
    do_coin(2'b10, 0);
    do_coin(2'b10, 0);
    idle(2);
    chk("d034_kind", last_kind, 3'b110);
    chk("d034_items", last_items, 6'b000011);
    chk("d034_change", last_change, 0);

    // Overpayment returns change.
    do_start(6'b000001, 5'd7);
    do_coin(2'b11, 0);
    idle(2);
    chk("d035_change", last_change, 3);

    // Cancel with a same-cycle coin refunds everything.
    d0 = disp_cnt;
    do_start(6'b000100, 5'd20);
    do_coin(2'b01, 0);
    do_coin(2'b00, 0);
    do_coin(2'b10, 1);
    idle(2);
    chk("d036_kind", last_kind, 3'b010);
    chk("d036_change", last_change, 8);
    chk("d036_no_dispense", disp_cnt, d0);

    // Timeout refund after TIMEOUT idle cycles.
    do_start(6'b001000, 5'd5);
    do_coin(2'b00, 0);
    idle(10);
    chk("d037_kind", last_kind, 3'b010);
    chk("d037_change", last_change, 1);

    // Rejected starts and coins while idle.
    do_start(6'b000000, 5'd5);
    idle(1);
    chk("d038_err_a", last_kind, 3'b001);
    last_kind = 3'b000;
    do_start(6'b000011, 5'd0);
    idle(1);
    chk("d038_err_b", last_kind, 3'b001);
    do_coin(2'b11, 0);
    idle(1);

    // Reset mid-purchase abandons it silently.
    do_start(6'b010000, 5'd20);
    do_coin(2'b10, 0);
    do_coin(2'b00, 0);
    clear_inputs(); reset = 1; step();
    idle(3);

    // Randomized traffic with varying coin rates.
    coin_pct = 30;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) begin
        case ($urandom_range(0, 2))
          0: coin_pct = 3;
          1: coin_pct = 30;
          default: coin_pct = 70;
        endcase
      end
      reset      = ($urandom_range(0, 299) == 0);
      start      = ($urandom_range(0, 3) == 0);
      commodity  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      total      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      coin_valid = ($urandom_range(0, 99) < coin_pct);
      coin_value = 2'($urandom);
      cancel     = ($urandom_range(0, 49) == 0);
      step();
    end

    idle(TIMEOUT + 4);
    chk("events_drained", evq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/vend_checkout.md
VEND_CHECKOUT -- requirements
Module: vend_checkout

Interface
REQ-001 Parameter TIMEOUT, default 1000, idle cycles in COLLECT before automatic refund.
REQ-002 Parameter N, default 6, commodity selection width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a purchase; sampled only in IDLE.
REQ-006 commodity  input  N  item selection bitmap, latched on accepted start.
REQ-007 total  input  5  price sum from the upstream pricing stage, latched on accepted start.
REQ-008 coin_valid  input  1  one-cycle coin insertion strobe.
REQ-009 coin_value  input  2  coin code: 00=1, 01=2, 10=5, 11=10 units.
REQ-010 cancel  input  1  customer abort request.
REQ-011 ready  output  1  high exactly when state is IDLE.
REQ-012 credit  output  6  accumulated credit for the current purchase.
REQ-013 dispense  output  1  one-cycle pulse: release latched items.
REQ-014 items  output  N  latched selection; valid while dispense=1, else 0.
REQ-015 change_valid  output  1  one-cycle pulse: change output valid.
REQ-016 change  output  6  amount returned; valid while change_valid=1, else 0.
REQ-017 err  output  1  one-cycle pulse on rejected start.

Function
REQ-018 States SHALL be IDLE, COLLECT, DISPENSE, REFUND; registered, encoded internally.
REQ-019 IDLE: start=1 with total!=0 and commodity!=0 SHALL latch price<=total, sel<=commodity, credit<=0, timer<=0, next COLLECT.
REQ-020 IDLE: start=1 with total=0 or commodity=0 SHALL pulse err for one cycle in the following cycle, stay IDLE.
REQ-021 start outside IDLE SHALL be ignored; coin_valid and cancel outside COLLECT SHALL be ignored.
REQ-022 COLLECT: coin_valid SHALL add decoded coin to credit (6-bit, no overflow possible: max 30+10=40) and clear timer.
REQ-023 COLLECT: no coin SHALL increment timer; timer reaching TIMEOUT-1 SHALL go to REFUND next cycle.
REQ-024 COLLECT: cancel=1 SHALL go to REFUND, with any same-cycle coin added to credit first; cancel has priority over payment completion.
REQ-025 COLLECT: if credit+coin >= price and cancel=0, next state SHALL be DISPENSE.
REQ-026 DISPENSE (one cycle): dispense=1, items=sel, change_valid=1, change=credit-price (0 allowed), then IDLE with credit<=0.
REQ-027 REFUND (one cycle): dispense=0, change_valid=1, change=credit (0 allowed), then IDLE with credit<=0.
REQ-028 Latency: coin completing payment at edge t SHALL give dispense at cycle t+1, ready at t+2.
REQ-029 credit output SHALL reflect the register value (updated the cycle after the coin).
REQ-030 Upstream total is trusted as-is; selections summing to 32 wrap to 0 upstream and SHALL be rejected via REQ-020.

Reset
REQ-031 reset=1 SHALL force IDLE in the next cycle regardless of state, abandoning any purchase without refund pulse.
REQ-032 Reset values: ready=1, credit=0, dispense=0, items=0, change_valid=0, change=0, err=0, timer=0, price=0, sel=0.
REQ-033 reset SHALL take priority over start, coin_valid and cancel in the same cycle.

Verification
REQ-034 start, commodity=000011, total=10; coins 5,5 -> dispense 1 cycle after second coin, items=000011, change=0, ready next cycle.
REQ-035 total=7; coin 10 -> dispense, change_valid with change=3.
REQ-036 total=20; coins 2,1 then cancel with coin 5 same cycle -> REFUND, change=8, dispense never asserted.
REQ-037 total=5, TIMEOUT=8; coin 1 then 8 idle cycles -> REFUND change=1, ready afterwards.
REQ-038 start with commodity=0 or total=0 -> err pulse, ready stays 1; coin_valid in IDLE -> credit stays 0.
REQ-039 reset asserted in COLLECT with credit=6 -> next cycle ready=1, credit=0, no change_valid pulse.
